// File: rtl/rf_sb.sv
// rf_sb: register file with a per-register busy scoreboard.
// Ports: clk/rst, two combinational read ports, one write port, and a reserve port.
//   Outputs: read data and busy per read port, registered busy count, sticky err.
module rf_sb #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1regsel,
  input  logic [ADDR_W-1:0] read2regsel,
  input  logic [ADDR_W-1:0] writeregsel,
  input  logic [WIDTH-1:0]  writedata,
  input  logic              write,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserveregsel,
  output logic [WIDTH-1:0]  read1data,
  output logic [WIDTH-1:0]  read2data,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  logic wr_ok;
  logic r0_res;
  logic rs_ok;
  logic same;
  logic z1;
  logic z2;
  logic byp1;
  logic byp2;
  logic set_evt;
  logic clr_evt;
  logic err_evt;

  // Register 0 is hard-wired to zero when ZERO_R0 is set.
  assign wr_ok  = write && !(ZERO_R0 != 0 && writeregsel == '0);
  assign r0_res = reserve && ZERO_R0 != 0 && reserveregsel == '0;
  assign rs_ok  = reserve && !r0_res;
  assign same   = writeregsel == reserveregsel;

  assign z1   = ZERO_R0 != 0 && read1regsel == '0;
  assign z2   = ZERO_R0 != 0 && read2regsel == '0;
  assign byp1 = BYPASS != 0 && wr_ok && writeregsel == read1regsel;
  assign byp2 = BYPASS != 0 && wr_ok && writeregsel == read2regsel;

  always_comb begin
    read1data = '0;
    read2data = '0;
    if (byp1) read1data = writedata;
    else if (!z1) read1data = regs[read1regsel];
    if (byp2) read2data = writedata;
    else if (!z2) read2data = regs[read2regsel];
  end

  // A forwarded write resolves the pending operand this cycle.
  assign busy1 = !byp1 && !z1 && busy[read1regsel];
  assign busy2 = !byp2 && !z2 && busy[read2regsel];

  // Reservation is applied after the clear so a same-register pair ends busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[writeregsel] = 1'b0;
    if (rs_ok) busy_nxt[reserveregsel] = 1'b1;
  end

  assign set_evt = rs_ok && !busy[reserveregsel];
  assign clr_evt = wr_ok && busy[writeregsel] && !(rs_ok && same);
  assign err_evt = (rs_ok && busy[reserveregsel] && !(wr_ok && same))
                 || r0_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (wr_ok) regs[writeregsel] <= writedata;
      busy <= busy_nxt;
      if (set_evt && !clr_evt) busy_cnt <= busy_cnt + CNT_ONE;
      else if (clr_evt && !set_evt) busy_cnt <= busy_cnt - CNT_ONE;
      if (err_evt) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_sb.sv
// tb_rf_sb: scoreboard bench for rf_sb, three parameter variants on shared inputs.
// DUT0 BYPASS=1/ZERO_R0=0, DUT1 BYPASS=0/ZERO_R0=0, DUT2 BYPASS=1/ZERO_R0=1.
module tb_rf_sb;

  logic        clk = 0;
  logic        rst;
  logic [2:0]  s1, s2, wsel, rsel;
  logic [15:0] wd;
  logic        wr, rs;

  logic [15:0] rd1 [3];
  logic [15:0] rd2 [3];
  logic        b1 [3];
  logic        b2 [3];
  logic [3:0]  cnt [3];
  logic        er [3];

  always #5 clk = ~clk;

  rf_sb #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) u0 (
    .clk(clk), .rst(rst), .read1regsel(s1), .read2regsel(s2),
    .writeregsel(wsel), .writedata(wd), .write(wr), .reserve(rs),
    .reserveregsel(rsel), .read1data(rd1[0]), .read2data(rd2[0]),
    .busy1(b1[0]), .busy2(b2[0]), .busy_cnt(cnt[0]), .err(er[0]));

  rf_sb #(.WIDTH(16), .ADDR_W(3), .BYPASS(0), .ZERO_R0(0)) u1 (
    .clk(clk), .rst(rst), .read1regsel(s1), .read2regsel(s2),
    .writeregsel(wsel), .writedata(wd), .write(wr), .reserve(rs),
    .reserveregsel(rsel), .read1data(rd1[1]), .read2data(rd2[1]),
    .busy1(b1[1]), .busy2(b2[1]), .busy_cnt(cnt[1]), .err(er[1]));

  rf_sb #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(1)) u2 (
    .clk(clk), .rst(rst), .read1regsel(s1), .read2regsel(s2),
    .writeregsel(wsel), .writedata(wd), .write(wr), .reserve(rs),
    .reserveregsel(rsel), .read1data(rd1[2]), .read2data(rd2[2]),
    .busy1(b1[2]), .busy2(b2[2]), .busy_cnt(cnt[2]), .err(er[2]));

  localparam int RD1 = 0, RD2 = 1, B1 = 2, B2 = 3, CNT = 4, ERR = 5;

  typedef struct {
    string       name;
    int          dut;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] actual(int d, int f);
    case (f)
      RD1:     return {16'h0, rd1[d]};
      RD2:     return {16'h0, rd2[d]};
      B1:      return {31'h0, b1[d]};
      B2:      return {31'h0, b2[d]};
      CNT:     return {28'h0, cnt[d]};
      default: return {31'h0, er[d]};
    endcase
  endfunction

  // Monitor: drains every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.dut, e.fld);
      checks++;
      if (a !== e.val) begin
        failures++;
        $display("FAIL %s dut%0d actual=%0h required=%0h",
                 e.name, e.dut, a, e.val);
      end
    end
  end

  task automatic ex3(string n, int f, logic [31:0] v0,
                     logic [31:0] v1, logic [31:0] v2);
    exp_t e;
    e.name = n; e.fld = f;
    e.dut = 0; e.val = v0; q.push_back(e);
    e.dut = 1; e.val = v1; q.push_back(e);
    e.dut = 2; e.val = v2; q.push_back(e);
  endtask

  task automatic drive(logic r, logic w, logic [2:0] ws, logic [15:0] d,
                       logic v, logic [2:0] vs, logic [2:0] a, logic [2:0] b);
    rst = r; wr = w; wsel = ws; wd = d;
    rs = v; rsel = vs; s1 = a; s2 = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick;
    // reset state
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    ex3("rst_cnt", CNT, 0, 0, 0);
    ex3("rst_err", ERR, 0, 0, 0);
    ex3("rst_rd1", RD1, 0, 0, 0);
    tick;
    // write r3 and read it back next cycle
    drive(0, 1, 3, 16'h1234, 0, 0, 3, 0);
    ex3("wr3_byp", RD1, 16'h1234, 0, 16'h1234);
    tick;
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    ex3("rd3", RD1, 16'h1234, 16'h1234, 16'h1234);
    ex3("rd3_busy", B1, 0, 0, 0);
    ex3("rd3_err", ERR, 0, 0, 0);
    tick;
    // same-cycle forwarding on port 2
    drive(0, 1, 5, 16'hBEEF, 0, 0, 0, 5);
    ex3("byp5", RD2, 16'hBEEF, 0, 16'hBEEF);
    tick;
    // reserve r2, r4, then write r2
    drive(0, 0, 0, 0, 1, 2, 2, 0);
    ex3("res2_b1", B1, 0, 0, 0);
    ex3("cnt0", CNT, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 4, 2, 4);
    ex3("r2_busy", B1, 1, 1, 1);
    ex3("cnt1", CNT, 1, 1, 1);
    tick;
    drive(0, 1, 2, 16'h0007, 0, 0, 2, 4);
    ex3("wb2_busy", B1, 0, 1, 0);
    ex3("wb2_rd", RD1, 7, 0, 7);
    ex3("r4_busy", B2, 1, 1, 1);
    ex3("cnt2", CNT, 2, 2, 2);
    tick;
    drive(0, 0, 0, 0, 0, 0, 2, 0);
    ex3("cnt1b", CNT, 1, 1, 1);
    ex3("r2_free", B1, 0, 0, 0);
    ex3("r2_val", RD1, 7, 7, 7);
    tick;
    // r6: reserve, then reserve+write same cycle, then double reserve
    drive(0, 0, 0, 0, 1, 6, 0, 0);
    ex3("cnt1c", CNT, 1, 1, 1);
    tick;
    drive(0, 1, 6, 16'hAAAA, 1, 6, 6, 0);
    ex3("rw6_b1", B1, 0, 1, 0);
    ex3("rw6_rd", RD1, 16'hAAAA, 0, 16'hAAAA);
    ex3("cnt2b", CNT, 2, 2, 2);
    tick;
    drive(0, 0, 0, 0, 0, 0, 6, 0);
    ex3("r6_val", RD1, 16'hAAAA, 16'hAAAA, 16'hAAAA);
    ex3("r6_busy", B1, 1, 1, 1);
    ex3("cnt2c", CNT, 2, 2, 2);
    ex3("rw6_err", ERR, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 6, 6, 0);
    ex3("pre_dbl_err", ERR, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 6, 0);
    ex3("dbl_err", ERR, 1, 1, 1);
    ex3("dbl_cnt", CNT, 2, 2, 2);
    ex3("dbl_busy", B1, 1, 1, 1);
    tick;
    ex3("err_sticky", ERR, 1, 1, 1);
    tick;
    // reset overrides write and reserve; state visible until edge
    drive(1, 1, 3, 16'h5555, 1, 3, 6, 4);
    ex3("inrst_cnt", CNT, 2, 2, 2);
    ex3("inrst_err", ERR, 1, 1, 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 6, 3);
    ex3("prst_cnt", CNT, 0, 0, 0);
    ex3("prst_err", ERR, 0, 0, 0);
    ex3("prst_rd1", RD1, 0, 0, 0);
    ex3("prst_rd2", RD2, 0, 0, 0);
    ex3("prst_b2", B2, 0, 0, 0);
    tick;
    // register 0 handling
    drive(0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
    ex3("wr0_byp", RD1, 16'hFFFF, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    ex3("rd0", RD1, 16'hFFFF, 16'hFFFF, 0);
    ex3("r0_b1", B1, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    ex3("res0_busy", B1, 1, 1, 0);
    ex3("res0_cnt", CNT, 1, 1, 0);
    ex3("res0_err", ERR, 0, 0, 1);
    tick;
    // fill the scoreboard
    for (int i = 1; i < 8; i++) begin
      drive(0, 0, 0, 0, 1, 3'(i), 0, 0);
      ex3("fill_cnt", CNT, 32'(i), 32'(i), 32'(i - 1));
      tick;
    end
    drive(0, 0, 0, 0, 1, 1, 1, 7);
    ex3("full_cnt", CNT, 8, 8, 7);
    ex3("full_err", ERR, 0, 0, 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 1, 7);
    ex3("full_dbl_err", ERR, 1, 1, 1);
    ex3("full_dbl_cnt", CNT, 8, 8, 7);
    ex3("full_b2", B2, 1, 1, 1);
    tick;
    // reset with a write in flight: bypass still visible before the edge
    drive(1, 1, 2, 16'h1234, 1, 2, 2, 7);
    ex3("rstw_byp", RD1, 16'h1234, 0, 16'h1234);
    ex3("rstw_cnt", CNT, 8, 8, 7);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 2);
    ex3("fin_cnt", CNT, 0, 0, 0);
    ex3("fin_err", ERR, 0, 0, 0);
    ex3("fin_rd1", RD1, 0, 0, 0);
    ex3("fin_rd2", RD2, 0, 0, 0);
    ex3("fin_b1", B1, 0, 0, 0);
    ex3("fin_b2", B2, 0, 0, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_sb.md
RF_SB -- requirements
Module: rf_sb

Interface
REQ-001 Parameter WIDTH, 16, data width of each register in bits.
REQ-002 Parameter ADDR_W, 3, register select width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports; when 0 reads return stored contents only.
REQ-004 Parameter ZERO_R0, 0, when 1 register 0 reads as zero and ignores writes and reservations.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 read1regsel  input  ADDR_W  read port 1 register select.
REQ-008 read2regsel  input  ADDR_W  read port 2 register select.
REQ-009 writeregsel  input  ADDR_W  write/writeback register select.
REQ-010 writedata  input  WIDTH  write data.
REQ-011 write  input  1  write enable; the write also clears that register's busy bit.
REQ-012 reserve  input  1  scoreboard reservation request; sets the busy bit of reserveregsel.
REQ-013 reserveregsel  input  ADDR_W  register to reserve.
REQ-014 read1data  output  WIDTH  port 1 read data, combinational.
REQ-015 read2data  output  WIDTH  port 2 read data, combinational.
REQ-016 busy1  output  1  port 1 operand pending, combinational.
REQ-017 busy2  output  1  port 2 operand pending, combinational.
REQ-018 busy_cnt  output  ADDR_W+1  number of registers with the busy bit set, registered.
REQ-019 err  output  1  sticky protocol error flag, registered.

Function
REQ-020 Storage SHALL be DEPTH registers of WIDTH bits plus DEPTH busy bits, all updated only on the rising edge of clk.
REQ-021 write=1 SHALL load writedata into reg[writeregsel] on the edge, except register 0 when ZERO_R0=1, which is discarded.
REQ-022 readNdata SHALL equal reg[readNregsel]; reading register 0 with ZERO_R0=1 SHALL return 0.
REQ-023 With BYPASS=1, a write that is not discarded and has writeregsel==readNregsel SHALL drive readNdata with writedata in the same cycle.
REQ-024 busyN SHALL equal busy[readNregsel], forced to 0 when BYPASS=1 and a matching, non-discarded write is present that cycle; with ZERO_R0=1, register 0 SHALL never be busy.
REQ-025 reserve=1 SHALL set busy[reserveregsel] on the edge; write=1 SHALL clear busy[writeregsel] on the edge.
REQ-026 reserve and write to the same register in the same cycle: data SHALL be written and busy SHALL end set (new reservation wins).
REQ-027 reserve and write to different registers in the same cycle SHALL both take effect.
REQ-028 busy_cnt SHALL increment by 1 when a register goes 0->1 and decrement by 1 when a register goes 1->0; when both happen in one cycle it SHALL be unchanged. It SHALL never wrap, and its range SHALL be 0..DEPTH.
REQ-029 err SHALL set one cycle after either condition: a reserve to an already-busy register not cleared by a same-register write that cycle; or a reserve of register 0 when ZERO_R0=1.
REQ-030 err SHALL remain set until reset; a double reservation SHALL leave busy set and busy_cnt unchanged.
REQ-031 A write to a non-busy register SHALL be legal: no err, and busy_cnt unchanged.

Reset
REQ-032 rst=1 at an edge SHALL clear all registers to 0, all busy bits to 0, busy_cnt to 0 and err to 0; it SHALL override any write or reserve in that cycle.
REQ-033 While rst=1, combinational read paths SHALL still reflect the current state and the bypass; no state SHALL change until the first edge with rst=0.

Verification
REQ-034 Apply reset, then write reg3=0x1234, then read1regsel=3 the next cycle -> read1data=0x1234, busy1=0, err=0.
REQ-035 BYPASS=1: write reg5=0xBEEF with read2regsel=5 in the same cycle -> read2data=0xBEEF before the edge; with BYPASS=0 -> read2data=old value 0x0000.
REQ-036 Reserve r2, then r4, then write r2=0x0007 -> busy_cnt sequence 1, 2, 1; busy1 on r2 is 1, then 0 during the write cycle with BYPASS=1.
REQ-037 Reserve r6 and, in the same cycle, write r6=0xAAAA while r6 is busy -> reg6=0xAAAA, busy[6]=1, busy_cnt unchanged, err=0; then reserve r6 again -> err=1 on the next cycle and stays 1.
REQ-038 ZERO_R0=1: write r0=0xFFFF, then read r0 -> 0x0000; reserve r0 -> err=1, busy_cnt=0.
REQ-039 Reserve all DEPTH registers (ZERO_R0=0) -> busy_cnt=DEPTH; assert rst mid-sequence -> the next cycle shows busy_cnt=0, err=0, and all reads 0.
